// File: rtl/rsa_pkg.sv
// Shared definitions for the masked-exponent datapath: word width, FSM encodings, legal NUM_WORDS range.
// EXPO_LZ_SKIP_EN selects whether leading zero bits are discarded before emission.
package rsa_pkg;

  localparam int WORD_W        = 32;
  localparam int BIT_CNT_W     = 5;
  localparam int NUM_WORDS_MIN = 1;
  localparam int NUM_WORDS_MAX = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_SHIFT = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // With skipping disabled the "leading one seen" tracker starts out set, so every bit is emitted.
`ifdef EXPO_LZ_SKIP_EN
  localparam logic SEEN_INIT = 1'b0;
`else
  localparam logic SEEN_INIT = 1'b1;
`endif

  function automatic int wcnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mask_expon_reader_shifter.sv
// Per-word MSB-first shift register with bit counter and leading-one tracking.
// Leading-one tracking only matters when EXPO_LZ_SKIP_EN is defined (see rsa_pkg::SEEN_INIT).
module expo_word_shifter
  import rsa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic [WORD_W-1:0]    data,
  input  logic                 advance,
  input  logic                 clear_seen,
  output logic                 msb,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 seen_one
);

  logic [WORD_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= data;
    end else if (advance) begin
      shreg <= {shreg[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt  <= '0;
      seen_one <= SEEN_INIT;
    end else begin
      if (load) begin
        bit_cnt <= '0;
      end else if (advance) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      // Once a one has left the register, the rest of the exponent is emitted verbatim.
      if (clear_seen) begin
        seen_one <= SEEN_INIT;
      end else if (advance && msb) begin
        seen_one <= 1'b1;
      end
    end
  end

  assign msb = shreg[WORD_W-1];

endmodule

// File: rtl/mask_expon_reader.sv
// Reads NUM_WORDS masked exponent words from the FIFO (MSW first) and serializes them MSB-first.
// Optional EXPO_LZ_SKIP_EN: discard leading zeros and flag an all-zero exponent on Zero_flag.
module mask_expon_reader
  import rsa_pkg::*;
#(
  parameter int NUM_WORDS = 2
) (
  input  logic              Clk,
  input  logic              Rstn,
  input  logic              Start,
  input  logic              Abort,
  input  logic [WORD_W-1:0] Expo_data,
  input  logic              Expo_empty,
  output logic              Rd_en_expo,
  output logic              Bit_o,
  output logic              Bit_valid,
  input  logic              Bit_ready,
  output logic              Last_bit,
  output logic              Busy,
  output logic              Done,
  output logic              Zero_flag
);

  localparam int                   WCNT_W    = wcnt_width(NUM_WORDS);
  localparam logic [WCNT_W-1:0]    LAST_WORD = WCNT_W'(NUM_WORDS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WORD_W - 1);

  state_t               state;
  state_t               state_nxt;
  logic [WCNT_W-1:0]    word_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 msb;
  logic                 seen_one;
  logic                 in_shift;
  logic                 bit_vld;
  logic                 advance;
  logic                 word_end;
  logic                 last_word;
  logic                 load;
  logic                 clear_seen;

  assign in_shift   = (state == ST_SHIFT);
  assign bit_vld    = in_shift & (seen_one | msb);
  // Discarded leading zeros advance unconditionally; emitted bits wait for the consumer.
  assign advance    = in_shift & (~bit_vld | Bit_ready);
  assign word_end   = advance & (bit_cnt == LAST_BIT);
  assign last_word  = (word_cnt == LAST_WORD);
  assign load       = (state == ST_LOAD) & ~Abort;
  assign clear_seen = (state == ST_IDLE);

  expo_word_shifter u_shifter (
    .clk        (Clk),
    .rstn       (Rstn),
    .load       (load),
    .data       (Expo_data),
    .advance    (advance),
    .clear_seen (clear_seen),
    .msb        (msb),
    .bit_cnt    (bit_cnt),
    .seen_one   (seen_one)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (Start) state_nxt = ST_REQ;
      ST_REQ:   if (!Expo_empty) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (word_end) state_nxt = last_word ? ST_DONE : ST_REQ;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (Abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (Abort || state == ST_DONE) begin
        word_cnt <= '0;
      end else if (word_end && !last_word) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

`ifdef EXPO_LZ_SKIP_EN
  logic zero_flag;

  // Latched on the final bit slot: zero when no one was seen up to and including it.
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      zero_flag <= 1'b0;
    end else if (!Abort && word_end && last_word) begin
      zero_flag <= ~(seen_one | msb);
    end
  end

  assign Zero_flag = zero_flag;
`else
  assign Zero_flag = 1'b0;
`endif

  // Read enable is gated by Abort/Rstn so an aborted request never pops a word.
  assign Rd_en_expo = (state == ST_REQ) & ~Expo_empty & ~Abort & Rstn;
  assign Bit_valid  = bit_vld;
  assign Bit_o      = bit_vld & msb;
  assign Last_bit   = bit_vld & last_word & (bit_cnt == LAST_BIT);
  assign Busy       = (state != ST_IDLE);
  assign Done       = (state == ST_DONE);

endmodule

// File: tb/tb_mask_expon_reader.sv
// Scoreboard bench for mask_expon_reader (NUM_WORDS=2); adapts expectations to EXPO_LZ_SKIP_EN.
module tb_mask_expon_reader;

  localparam int NW = 2;
`ifdef EXPO_LZ_SKIP_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rstn = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [31:0] Expo_data = '0;
  logic        Expo_empty;
  logic        Rd_en_expo;
  logic        Bit_o;
  logic        Bit_valid;
  logic        Bit_ready = 1'b1;
  logic        Last_bit;
  logic        Busy;
  logic        Done;
  logic        Zero_flag;

  always #5 Clk = ~Clk;

  mask_expon_reader #(.NUM_WORDS(NW)) dut (
    .Clk        (Clk),
    .Rstn       (Rstn),
    .Start      (Start),
    .Abort      (Abort),
    .Expo_data  (Expo_data),
    .Expo_empty (Expo_empty),
    .Rd_en_expo (Rd_en_expo),
    .Bit_o      (Bit_o),
    .Bit_valid  (Bit_valid),
    .Bit_ready  (Bit_ready),
    .Last_bit   (Last_bit),
    .Busy       (Busy),
    .Done       (Done),
    .Zero_flag  (Zero_flag)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: data appears the cycle after a read enable
  logic [31:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;

  assign Expo_empty = (wr_ptr == rd_ptr);

  always @(posedge Clk) begin
    if (Rd_en_expo) begin
      Expo_data <= fifo_mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
      rd_cnt    <= rd_cnt + 1;
    end
  end

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  // Bit_ready: constant 1, or the 1,0,0,1 backpressure pattern
  bit bp_mode = 1'b0;
  int bp_phase = 0;

  always @(posedge Clk) begin
    #1;
    if (bp_mode) begin
      Bit_ready = ((bp_phase % 4) == 0) || ((bp_phase % 4) == 3);
      bp_phase++;
    end else begin
      Bit_ready = 1'b1;
    end
  end

  // Scoreboard: {bit, last} per expected transfer
  logic [1:0]  exp_q[$];
  bit          exp_zero = 1'b0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] cap = '0;
  logic        prev_stall = 1'b0;
  logic        prev_bit = 1'b0;
  logic        prev_last = 1'b0;
  logic        prev_last_xfer = 1'b0;

  always @(negedge Clk) begin
    logic [1:0] e;
    if (Rd_en_expo && Expo_empty) chk("rd_on_empty", 1, 0);
    if (prev_stall && Bit_valid) begin
      chk("stall_bit", Bit_o, prev_bit);
      chk("stall_last", Last_bit, prev_last);
    end
    if (prev_last_xfer) chk("done_lag", Done, 1);
    if (Done) begin
      done_cnt++;
      chk("zero_flag", Zero_flag, exp_zero);
    end
    if (Bit_valid && Bit_ready) begin
      xfer_cnt++;
      cap = {cap[30:0], Bit_o};
      if (exp_q.size() == 0) begin
        chk("extra_bit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("bit", Bit_o, e[1]);
        chk("last", Last_bit, e[0]);
      end
    end
    prev_stall     = Bit_valid && !Bit_ready;
    prev_bit       = Bit_o;
    prev_last      = Last_bit;
    prev_last_xfer = Bit_valid && Bit_ready && Last_bit;
  end

  function automatic logic [6:0] outs();
    return {Rd_en_expo, Bit_o, Bit_valid, Last_bit, Busy, Done, Zero_flag};
  endfunction

  task automatic expect_expo(input logic [63:0] e, output int nbits);
    bit seen;
    seen  = !LZ;
    nbits = 0;
    for (int i = 63; i >= 0; i--) begin
      if (seen || e[i]) begin
        seen = 1'b1;
        exp_q.push_back({e[i], (i == 0)});
        nbits++;
      end
    end
    exp_zero = LZ && (e == 64'd0);
  endtask

  task automatic start_pulse();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge Clk); #1;
      n++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic wait_xfers(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (xfer_cnt < target && n < budget) begin
      @(negedge Clk); #1;
      n++;
    end
    chk(tag, xfer_cnt, target);
  endtask

  // Runs one exponent e = {w0, w1}; w0 is pushed only when push0 is set (else already queued).
  task automatic run_expo(input string tag, input logic [63:0] e, input bit push0);
    int nb;
    int x0;
    int r0;
    if (push0) push_word(e[63:32]);
    push_word(e[31:0]);
    expect_expo(e, nb);
    x0 = xfer_cnt;
    r0 = rd_cnt;
    start_pulse();
    wait_done({tag, "_done"}, 600);
    chk({tag, "_bits"}, xfer_cnt - x0, nb);
    chk({tag, "_reads"}, rd_cnt - r0, 2);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int x0;
    int r0;

    // Reset state
    Rstn = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outs", outs(), 7'd0);
    @(posedge Clk); #1 Rstn = 1'b1;

    // First-bit latency and basic stream
    push_word(32'h8000_0001);
    push_word(32'h8000_0001);
    expect_expo(64'h8000_0001_8000_0001, nb);
    x0 = xfer_cnt;
    @(posedge Clk); #1 Start = 1'b1;
    @(negedge Clk);
    chk("c0_busy", Busy, 0);
    @(posedge Clk); #1 Start = 1'b0;
    @(negedge Clk);
    chk("c1_rd_en", Rd_en_expo, 1);
    @(negedge Clk);
    chk("c2_valid", Bit_valid, 0);
    @(negedge Clk);
    chk("c3_valid", Bit_valid, 1);
    wait_done("basic_done", 600);
    chk("basic_bits", xfer_cnt - x0, nb);

    // Backpressure
    bp_phase = 0;
    bp_mode  = 1'b1;
    run_expo("bp", 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
    chk("bp_word", cap, 32'hA5A5_A5A5);
    bp_mode = 1'b0;

    // Empty stall before the second word
    push_word(32'hC3A5_5A3C);
    expect_expo(64'hC3A5_5A3C_9ABC_DEF0, nb);
    x0 = xfer_cnt;
    r0 = rd_cnt;
    start_pulse();
    wait_xfers("stall_w0", x0 + 32, 200);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("stall_quiet", {Rd_en_expo, Bit_valid}, 2'b00);
    end
    @(posedge Clk); #1 push_word(32'h9ABC_DEF0);
    @(negedge Clk);
    chk("rd_after_empty", Rd_en_expo, 1);
    wait_done("stall_done", 600);
    chk("stall_bits", xfer_cnt - x0, nb);
    chk("stall_reads", rd_cnt - r0, 2);

    // Leading zeros across the word boundary
    run_expo("lz", 64'h0000_0000_0000_0005, 1'b1);

    // Abort during bit 10 of word 0
    push_word(32'hF0E1_D2C3);
    push_word(32'h1111_2222);
    expect_expo(64'hF0E1_D2C3_1111_2222, nb);
    x0 = xfer_cnt;
    start_pulse();
    wait_xfers("abort_pos", x0 + 10, 200);
    @(posedge Clk); #1 Abort = 1'b1;
    @(posedge Clk); #1 Abort = 1'b0;
    exp_q.delete();
    @(negedge Clk);
    chk("abort_outs", outs(), 7'd0);
    r0 = rd_cnt;
    repeat (5) @(negedge Clk);
    chk("abort_no_rd", rd_cnt - r0, 0);
    run_expo("post_abort", 64'h1111_2222_3C3C_0F0F, 1'b0);

    // All-zero exponent
    run_expo("allz", 64'd0, 1'b1);

    // Reset mid-SHIFT
    push_word(32'h8421_0842);
    push_word(32'h7777_3333);
    expect_expo(64'h8421_0842_7777_3333, nb);
    x0 = xfer_cnt;
    start_pulse();
    wait_xfers("rst_pos", x0 + 5, 200);
    @(posedge Clk); #1 Rstn = 1'b0;
    @(posedge Clk); #1 Rstn = 1'b1;
    exp_q.delete();
    exp_zero = 1'b0;
    @(negedge Clk);
    chk("rst_outs", outs(), 7'd0);
    r0 = rd_cnt;
    repeat (5) @(negedge Clk);
    chk("rst_no_rd", rd_cnt - r0, 0);
    run_expo("post_rst", 64'h7777_3333_9669_1EE1, 1'b0);

    repeat (3) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
